multdiv_sequencer: RTL and testbench

Multi-cycle signed multiply/divide unit and its controller for the pipelined processor's execute stage. The combinational ALU cannot deliver a full 32×32 product or a 32/32 quotient in one pipeline cycle. This block takes a one-cycle start pulse, iterates one bit per clock, and raises `busy` so the hazard logic can stall. It then returns a registered 32-bit result with an exception flag on a one-cycle ready pulse.

---
 rtl/multdiv_pkg.sv | 8 +
 rtl/carry_select_adder.sv | 23 ++
 rtl/multdiv_step.sv | 23 ++
 rtl/multdiv_sequencer.sv | 92 +++++++++
 tb/tb_multdiv_sequencer.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/multdiv_pkg.sv
// multdiv_pkg: shared states, op codes and default widths for the multiply/divide sequencer
package multdiv_pkg;
  localparam int MD_DATA_W = 32;
  localparam int MD_CNT_W = 6;
  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV = 5'b00111;
  typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_SIGN, S_DONE} state_t;
endpackage

// File: rtl/carry_select_adder.sv
// carry_select_adder: blockwise adder choosing precomputed sums by the incoming block carry
module carry_select_adder #(
  parameter int W = 32,
  parameter int BLK = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o
);
  localparam int N = W / BLK;
  logic [N:0] c;
  assign c[0] = cin_i;
  for (genvar i = 0; i < N; i++) begin : g_blk
    logic [BLK:0] s0, s1;
    assign s0 = {1'b0, a_i[i*BLK +: BLK]} + {1'b0, b_i[i*BLK +: BLK]};
    assign s1 = s0 + (BLK+1)'(1);
    assign sum_o[i*BLK +: BLK] = c[i] ? s1[BLK-1:0] : s0[BLK-1:0];
    assign c[i+1] = c[i] ? s1[BLK] : s0[BLK];
  end
  assign cout_o = c[N];
endmodule

// File: rtl/multdiv_step.sv
// multdiv_step: one shift-add multiply or restoring-divide iteration on the product register
module multdiv_step import multdiv_pkg::*; #(
  parameter int DATA_W = MD_DATA_W
) (
  input  logic [4:0]          op_i,
  input  logic [2*DATA_W-1:0] p_i,
  input  logic [DATA_W-1:0]   m_i,
  output logic [2*DATA_W-1:0] p_o
);
  logic is_div, co, take;
  logic [2*DATA_W-1:0] sh;
  logic [DATA_W-1:0] x, y, s;
  assign is_div = op_i == OP_DIV;
  assign sh = {p_i[2*DATA_W-2:0], 1'b0};
  assign x = is_div ? sh[2*DATA_W-1:DATA_W] : p_i[2*DATA_W-1:DATA_W];
  assign y = is_div ? ~m_i : (p_i[0] ? m_i : '0);
  carry_select_adder #(.W(DATA_W)) u_add (
    .a_i(x), .b_i(y), .cin_i(is_div), .sum_o(s), .cout_o(co)
  );
  // a set bit shifted out of the remainder means the trial subtract cannot borrow
  assign take = p_i[2*DATA_W-1] | co;
  assign p_o = is_div ? {take ? s : x, sh[DATA_W-1:1], take} : {co, s, p_i[DATA_W-1:1]};
endmodule

// File: rtl/multdiv_sequencer.sv
// multdiv_sequencer: bit-serial signed multiply/divide with busy stall and one-cycle ready pulse
module multdiv_sequencer import multdiv_pkg::*; #(
  parameter int DATA_W = MD_DATA_W,
  parameter int CNT_W = MD_CNT_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ctrl_MULT,
  input  logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_operandA,
  input  logic [DATA_W-1:0] data_operandB,
  output logic [DATA_W-1:0] data_result,
  output logic              data_exception,
  output logic              data_resultRDY,
  output logic              busy
);
  state_t state_q;
  logic [4:0] op_q;
  logic neg_q, exc_q, rdy_q, busy_q, accept, last;
  logic [CNT_W-1:0] cnt_q;
  logic [DATA_W-1:0] m_q, result_q, abs_a, abs_b, quo;
  logic [2*DATA_W-1:0] p_q, p_step, prod;
  multdiv_step #(.DATA_W(DATA_W)) u_step (.op_i(op_q), .p_i(p_q), .m_i(m_q), .p_o(p_step));
  assign accept = (state_q == S_IDLE || state_q == S_DONE) && (ctrl_MULT || ctrl_DIV);
  assign last = cnt_q == CNT_W'(DATA_W-1);
  assign abs_a = data_operandA[DATA_W-1] ? -data_operandA : data_operandA;
  assign abs_b = data_operandB[DATA_W-1] ? -data_operandB : data_operandB;
  assign prod = neg_q ? -p_q : p_q;
  assign quo = neg_q ? -p_q[DATA_W-1:0] : p_q[DATA_W-1:0];
  assign data_result = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy = busy_q;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q <= OP_MULT;
      neg_q <= 1'b0;
      cnt_q <= '0;
      m_q <= '0;
      p_q <= '0;
      result_q <= '0;
      exc_q <= 1'b0;
      rdy_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            op_q <= ctrl_MULT ? OP_MULT : OP_DIV;
            neg_q <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            cnt_q <= '0;
            m_q <= ctrl_MULT ? abs_a : abs_b;
            p_q <= {{DATA_W{1'b0}}, ctrl_MULT ? abs_b : abs_a};
            state_q <= ctrl_MULT ? S_MULT : S_DIV;
            busy_q <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_MULT, S_DIV: begin
          if (state_q == S_DIV && m_q == '0) begin
            result_q <= '0;
            exc_q <= 1'b1;
            rdy_q <= 1'b1;
            busy_q <= 1'b0;
            state_q <= S_DONE;
          end else begin
            p_q <= p_step;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) state_q <= S_SIGN;
          end
        end
        S_SIGN: begin
          // product overflows unless its top DATA_W+1 bits are a pure sign extension
          result_q <= op_q == OP_MULT ? prod[DATA_W-1:0] : quo;
          exc_q <= op_q == OP_MULT ? ~(&prod[2*DATA_W-1:DATA_W-1] | ~|prod[2*DATA_W-1:DATA_W-1])
                                   : ~neg_q & p_q[DATA_W-1];
          rdy_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= S_DONE;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_multdiv_sequencer.sv
// tb_multdiv_sequencer: directed and randomized checks of the multiply/divide sequencer
module tb_multdiv_sequencer;
  logic clock = 1'b0;
  logic reset, ctrl_MULT, ctrl_DIV;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic data_exception, data_resultRDY, busy;
  int n_chk = 0;
  int n_pass = 0;

  multdiv_sequencer dut (
    .clock(clock), .reset(reset), .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [32:0] ref_op(input bit m, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (!m && b == 0) return {1'b1, 32'h0};
    r = m ? longint'($signed(a)) * longint'($signed(b)) : longint'($signed(a)) / longint'($signed(b));
    return {r != longint'(int'(r)), r[31:0]};
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 3))
      0: return 32'($urandom_range(0, 40)) - 32'd20;
      1: return $urandom_range(0, 1) ? 32'h8000_0000 : 32'hFFFF_FFFF;
      2: return 32'($urandom_range(0, 16'hFFFF)) << $urandom_range(0, 16);
      default: return $urandom;
    endcase
  endfunction

  task automatic drive_start(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT = m;
    ctrl_DIV = d;
    data_operandA = a;
    data_operandB = b;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int c0, input int lat, input logic [31:0] res, input bit exc);
    int c = c0;
    int nb = 0;
    while (!data_resultRDY && c < c0 + 60) begin
      if (busy) nb++;
      @(negedge clock);
      c++;
    end
    chk({tag, "_lat"}, 64'(c), 64'(lat));
    chk({tag, "_busy"}, 64'(nb), 64'(lat - c0));
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
    chk({tag, "_res"}, 64'(data_result), 64'(res));
    chk({tag, "_exc"}, 64'(exc), 64'(data_exception));
  endtask

  task automatic run(input string tag, input bit m, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] r;
    r = ref_op(m, a, b);
    drive_start(m, !m, a, b);
    wait_done(tag, 1, (!m && b == 0) ? 2 : 34, r[31:0], r[32]);
  endtask

  initial begin
    int nr;
    logic [32:0] r;
    reset = 1'b1;
    ctrl_MULT = 1'b0;
    ctrl_DIV = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(negedge clock);
    chk("rst_res", 64'(data_result), 64'd0);
    chk("rst_exc", 64'(data_exception), 64'd0);
    chk("rst_rdy", 64'(data_resultRDY), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    drive_start(1'b1, 1'b0, 32'd7, -32'sd6);
    wait_done("mul_7x-6", 1, 34, 32'hFFFF_FFD6, 1'b0);
    @(negedge clock);
    chk("rdy_one_cycle", 64'(data_resultRDY), 64'd0);
    chk("res_held", 64'(data_result), 64'hFFFF_FFD6);

    drive_start(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
    wait_done("mul_ovf", 1, 34, 32'h0, 1'b1);
    drive_start(1'b1, 1'b0, 32'h8000_0000, 32'd1);
    wait_done("mul_min", 1, 34, 32'h8000_0000, 1'b0);
    drive_start(1'b0, 1'b1, -32'sd7, 32'd2);
    wait_done("div_-7/2", 1, 34, 32'hFFFF_FFFD, 1'b0);
    drive_start(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 1, 34, 32'h8000_0000, 1'b1);
    drive_start(1'b0, 1'b1, 32'd5, 32'd0);
    wait_done("div_zero", 1, 2, 32'h0, 1'b1);

    drive_start(1'b1, 1'b0, 32'd123, -32'sd45);
    repeat (4) @(negedge clock);
    data_operandA = 32'd1000;
    data_operandB = 32'd10;
    ctrl_DIV = 1'b1;
    @(negedge clock);
    ctrl_DIV = 1'b0;
    wait_done("mul_ignore_div", 6, 34, 32'hFFFF_EA61, 1'b0);

    drive_start(1'b1, 1'b1, 32'd100, 32'd7);
    wait_done("both_start", 1, 34, 32'd700, 1'b0);

    drive_start(1'b1, 1'b0, 32'd3, 32'd5);
    wait_done("b2b_first", 1, 34, 32'd15, 1'b0);
    drive_start(1'b0, 1'b1, -32'sd8, 32'd3);
    wait_done("b2b_second", 1, 34, 32'hFFFF_FFFE, 1'b0);

    drive_start(1'b1, 1'b0, 32'd9, 32'd9);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_res", 64'(data_result), 64'd0);
    chk("midrst_exc", 64'(data_exception), 64'd0);
    chk("midrst_rdy", 64'(data_resultRDY), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    nr = 0;
    repeat (40) begin
      @(negedge clock);
      if (data_resultRDY) nr++;
    end
    chk("midrst_no_rdy", 64'(nr), 64'd0);
    drive_start(1'b1, 1'b0, -32'sd12, -32'sd11);
    wait_done("after_rst", 1, 34, 32'd132, 1'b0);

    repeat (24) begin
      bit m;
      logic [31:0] a, b;
      m = 1'($urandom_range(0, 1));
      a = rnd_val();
      b = ($urandom_range(0, 9) == 0) ? 32'd0 : rnd_val();
      r = ref_op(m, a, b);
      run(m ? "rnd_mul" : "rnd_div", m, a, b);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
